// File: rtl/seq_cla_pkg.sv
// -----------------------------------------------------------------------------
// seq_cla_pkg
// Shared definitions for the sequential carry-lookahead adder:
//   - state_e       : controller states (IDLE / RUN / DONE)
//   - DEFAULT_WIDTH : default operand/result width
//   - DEFAULT_CHUNK : default number of bits added per cycle
//   - num_chunks()  : number of chunk cycles, WIDTH / CHUNK
//   - idx_width()   : chunk index width, clog2(N) with a minimum of 1
// -----------------------------------------------------------------------------
package seq_cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk adder still gets a one-bit index so the register is never
    // zero width.
    function automatic int idx_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_cla_adder_chunk.sv
// -----------------------------------------------------------------------------
// cla_chunk
// Combinational CHUNK-bit carry-lookahead adder slice.
//   a, b   : CHUNK-bit addends
//   cin    : carry into bit 0
//   sum    : CHUNK-bit sum
//   cout   : carry out of bit CHUNK-1
//   c_msb  : carry into bit CHUNK-1 (used for signed overflow on the top chunk)
// -----------------------------------------------------------------------------
module cla_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded into its flat sum-of-products form
    //   c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
    // so no carry depends on another carry (true lookahead, not ripple).
    always_comb begin
        logic ci;
        logic prop;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            ci   = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                ci   = ci | (prop & g[j]);
                prop = prop & p[j];
            end
            ci       = ci | (prop & cin);
            c[i+1]   = ci;
        end
    end

    assign sum   = p ^ c[CHUNK-1:0];
    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_cla_adder.sv
// -----------------------------------------------------------------------------
// seq_cla_adder
// Multi-cycle adder/subtractor: one CHUNK-bit carry-lookahead slice is reused
// for N = WIDTH/CHUNK cycles, least-significant chunk first. A start accepted
// in cycle 0 gives done in cycle N+1.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   start      : begin an operation (accepted in IDLE or DONE only)
//   a, b       : WIDTH-bit operands (sampled only in the accept cycle)
//   cin        : carry-in
//   sub        : 0 = a + b + cin, 1 = a + ~b + ~cin (a - b - cin)
//   busy       : high while chunks are being processed
//   done       : one-cycle pulse, result valid
//   sum        : result, held until the next done
//   cout       : carry out of the MSB (for subtract: 1 = no borrow)
//   overflow   : signed overflow (carry into MSB xor carry out of MSB)
//   state_dbg  : current controller state, for observation only
//
// Handshake: start is sampled on every rising edge; it takes effect only when
// busy is 0. A start presented in the DONE cycle launches the next operation
// with no idle cycle. WIDTH must be a non-zero multiple of CHUNK.
// -----------------------------------------------------------------------------
module seq_cla_adder
    import seq_cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output state_e           state_dbg
);

    localparam int N  = num_chunks(WIDTH, CHUNK);
    localparam int IW = idx_width(WIDTH, CHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    // Operands and partial sum are stored chunk-addressable so the slice
    // select is a plain array index by the chunk counter.
    state_e                       state_q, state_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [N-1:0][CHUNK-1:0]      a_q, a_d;
    logic [N-1:0][CHUNK-1:0]      b_q, b_d;
    logic                         carry_q, carry_d;
    logic [N-1:0][CHUNK-1:0]      psum_q, psum_d;
    logic [WIDTH-1:0]             sum_q, sum_d;
    logic                         cout_q, cout_d;
    logic                         ovf_q, ovf_d;

    logic [CHUNK-1:0]             chunk_a;
    logic [CHUNK-1:0]             chunk_b;
    logic [CHUNK-1:0]             chunk_sum;
    logic                         chunk_cout;
    logic                         chunk_cmsb;

    assign chunk_a = a_q[idx_q];
    assign chunk_b = b_q[idx_q];

    cla_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (chunk_a),
        .b     (chunk_b),
        .cin   (carry_q),
        .sum   (chunk_sum),
        .cout  (chunk_cout),
        .c_msb (chunk_cmsb)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b and the carry here
                    // so the RUN datapath is always a plain add.
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = cin ^ sub;
                    idx_d   = '0;
                    psum_d  = '0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                psum_d[idx_q] = chunk_sum;
                carry_d       = chunk_cout;
                if (idx_q == LAST_IDX) begin
                    // Visible outputs change only here, so partial sums never
                    // leak out while the operation is in flight.
                    state_d = DONE;
                    sum_d   = psum_d;
                    cout_d  = chunk_cout;
                    ovf_d   = chunk_cmsb ^ chunk_cout;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            psum_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: doc/seq_cla_adder.md
SEQ_CLA_ADDER -- requirements
Module: seq_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of CHUNK, and WIDTH >= CHUNK.
REQ-002 Parameter CHUNK, default 4, bits added per cycle by the carry-lookahead slice.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  request to begin an operation; sampled every cycle.
REQ-006 a  input  WIDTH  operand A, unsigned or two's-complement.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in.
REQ-009 sub  input  1  mode: 0 = add, 1 = subtract.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when the result is valid.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of the MSB.
REQ-014 overflow  output  1  signed overflow flag.

Function
REQ-015 FSM states: IDLE, RUN, DONE.
REQ-016 In IDLE or DONE, start=1 SHALL latch a, b, cin and sub, clear the chunk index, clear the partial sum and enter RUN.
  - The latched B operand is b XOR {WIDTH{sub}}.
  - The latched carry is cin XOR sub.
REQ-017 In RUN, chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) is processed once per cycle, for k = 0 .. N-1, where N = WIDTH/CHUNK.
  - The chunk sum is written into the partial-sum register.
  - The chunk carry-out becomes the next chunk's carry-in.
REQ-018 After chunk N-1, the FSM SHALL enter DONE. Start sampled in cycle 0 therefore gives done=1 in cycle N+1 (latency N+1 cycles).
REQ-019 In DONE, done=1 for exactly one cycle, and sum, cout and overflow are updated in that same cycle.
REQ-020 In DONE with start=0, the FSM SHALL return to IDLE; in DONE with start=1, REQ-016 applies (back-to-back operation, no idle cycle).
REQ-021 busy SHALL be 1 in RUN only; it is 0 in IDLE and DONE.
REQ-022 start while busy=1 SHALL be ignored; the in-flight operands and result are unaffected.
REQ-023 Operand inputs SHALL be don't-care except in the start-accept cycle.
REQ-024 sum, cout and overflow SHALL hold their last result until the next DONE; they SHALL NOT show partial values.
REQ-025 cout is the final chunk carry-out. With sub=1 and cin=0, cout=1 means no borrow (a >= b unsigned).
REQ-026 overflow SHALL be the XOR of the carry into and the carry out of bit WIDTH-1.
REQ-027 All arithmetic is modulo 2^WIDTH; there is no saturation.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force IDLE and set busy, done, sum, cout, overflow, the chunk index and all internal registers to 0.
REQ-029 Reset mid-RUN SHALL abort the operation: no done pulse, and the result is not retained.
REQ-030 Reset SHALL take priority over start in the same cycle.
REQ-031 After reset is released, the first start SHALL be accepted normally.

Structure
REQ-032 A shared package seq_cla_pkg SHALL hold:
  - the FSM state enum (IDLE/RUN/DONE);
  - the default WIDTH and CHUNK constants;
  - a function computing N and the index width, clog2(N), minimum 1.
REQ-033 A sub-module cla_chunk (parameter CHUNK) SHALL implement the combinational CHUNK-bit carry-lookahead add.
  - Outputs: chunk sum, carry-out, and carry into its MSB (used for overflow).
  - The sub-module is instantiated once and reused every RUN cycle.

Verification
REQ-034 Default parameters; a=0x0005, b=0x0009, cin=0, sub=0, start pulse -> done in cycle 5 with sum=0x000E, cout=0, overflow=0; busy high in cycles 1-4.
REQ-035 a=0xFFFF, b=0x0001, add -> sum=0x0000, cout=1, overflow=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
REQ-036 Subtract: a=0x0003, b=0x0005, cin=0, sub=1 -> sum=0xFFFE, cout=0, overflow=0.
  - Then start held in the DONE cycle with a=0x0009, b=0x0004, sub=1 -> next sum=0x0005, cout=1, with no idle gap.
REQ-037 Start with a=0x1234, b=0x1111, then start=1 in cycle 2 with a=0xFFFF -> only one done, with sum=0x2345.
  - Separately, rst_n=0 in cycle 3 of an operation -> no done, all outputs 0, FSM in IDLE.
REQ-038 WIDTH=8, CHUNK=4: a=11, b=4 -> sum=15, done in cycle 3; a=15, b=9 -> sum=0x18, cout=0.
  - WIDTH=4, CHUNK=4 (N=1): a=15, b=9 -> sum=8, cout=1.
